// File: rtl/outport_display_scanner.sv
// outport_display_scanner
// Latches CPU writes to the output port and drives a time-multiplexed,
// active-low seven-segment display from the latched value. The displayed
// value only changes at a frame boundary, so a frame never mixes two values.
module outport_display_scanner #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DIGITS   = 8
) (
    input  logic              fast_clk,
    input  logic              reset_n,
    input  logic              outport_wr,
    input  logic [31:0]       bus_data,
    input  logic              blank_lz,
    output logic [31:0]       outport_q,
    output logic [7:0]        seg_out,
    output logic [DIGITS-1:0] digit_en_n,
    output logic              frame_done
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = 4 * DIGITS;

    logic [PW-1:0]     prescale;
    logic [IW-1:0]     digit_idx;
    logic [31:0]       shadow;
    logic [VW-1:0]     disp;
    logic              pending;

    logic              digit_wrap;
    logic              frame_wrap;
    logic [DIGITS-1:0] zero_from;
    logic [3:0]        cur_nibble;
    logic              cur_blank;
    logic [7:0]        seg_next;
    logic [DIGITS-1:0] en_next;

    // Active-low hex decode, dp held off
    function automatic logic [7:0] hex_decode(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign digit_wrap = (prescale == PW'(SCAN_DIV - 1));
    assign frame_wrap = digit_wrap && (digit_idx == IW'(DIGITS - 1));
    assign outport_q  = shadow;

    // Prescaler and digit scan position
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale  <= '0;
            digit_idx <= '0;
        end else if (digit_wrap) begin
            prescale <= '0;
            if (digit_idx == IW'(DIGITS - 1)) begin
                digit_idx <= '0;
            end else begin
                digit_idx <= digit_idx + IW'(1);
            end
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    // Write capture and frame-synchronous display update
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (outport_wr) begin
                shadow <= bus_data;
            end
            // A write landing on the boundary cycle bypasses shadow so it
            // is shown in the frame that starts right now.
            if (frame_wrap) begin
                if (outport_wr) begin
                    disp <= bus_data[VW-1:0];
                end else if (pending) begin
                    disp <= shadow[VW-1:0];
                end
                pending <= 1'b0;
            end else if (outport_wr) begin
                pending <= 1'b1;
            end
            frame_done <= frame_wrap;
        end
    end

    // Select the current digit's nibble, blanking and enable pattern
    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        zero_from  = '0;
        cur_nibble = '0;
        cur_blank  = 1'b0;
        en_next    = '1;
        for (int unsigned j = DIGITS; j > 0; j--) begin
            all_zero       = all_zero && (disp[4*(j-1) +: 4] == 4'h0);
            zero_from[j-1] = all_zero;
        end
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digit_idx == IW'(i)) begin
                cur_nibble = disp[4*i +: 4];
                cur_blank  = blank_lz && (i != 0) && zero_from[i];
                en_next[i] = 1'b0;
            end
        end
        seg_next = cur_blank ? 8'hFF : hex_decode(cur_nibble);
    end

    // Registered display pins
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_out    <= 8'hFF;
            digit_en_n <= '1;
        end else begin
            seg_out    <= seg_next;
            digit_en_n <= en_next;
        end
    end

endmodule

// File: tb/tb_outport_display_scanner.sv
// Scoreboard bench for outport_display_scanner (SCAN_DIV=4, DIGITS=8).
// Expected pin values come from a timeline model: edges counted since reset
// release, a log of writes, and the displayed value taken as the latest
// write at or before the most recent frame-boundary edge.
module tb_outport_display_scanner;

    localparam int SD = 4;
    localparam int ND = 8;
    localparam int FR = SD * ND;

    logic        fast_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        outport_wr = 1'b0;
    logic [31:0] bus_data = '0;
    logic        blank_lz = 1'b0;
    logic [31:0] outport_q;
    logic [7:0]  seg_out;
    logic [7:0]  digit_en_n;
    logic        frame_done;

    outport_display_scanner #(.SCAN_DIV(SD), .DIGITS(ND)) dut (
        .fast_clk  (fast_clk),
        .reset_n   (reset_n),
        .outport_wr(outport_wr),
        .bus_data  (bus_data),
        .blank_lz  (blank_lz),
        .outport_q (outport_q),
        .seg_out   (seg_out),
        .digit_en_n(digit_en_n),
        .frame_done(frame_done)
    );

    always #5 fast_clk = ~fast_clk;

    typedef struct packed {
        logic [7:0]  seg;
        logic [7:0]  en;
        logic [31:0] q;
        logic        fd;
    } exp_t;

    exp_t        expq[$];
    int unsigned wr_edge[$];
    logic [31:0] wr_val[$];
    int unsigned k = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  hex_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [31:0] last_write(input int unsigned upto);
        logic [31:0] v = '0;
        for (int i = 0; i < wr_edge.size(); i++)
            if (wr_edge[i] <= upto) v = wr_val[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%h expected=%h", name, k, act, exp);
        end
    endtask

    // Predictor: at each edge, derive what the pins must show after it
    always @(posedge fast_clk) begin
        exp_t        e;
        int unsigned bprev, d;
        logic [31:0] dv, upper;
        if (!reset_n) begin
            k = 0;
            wr_edge.delete();
            wr_val.delete();
            e.seg = 8'hFF;
            e.en  = 8'hFF;
            e.q   = '0;
            e.fd  = 1'b0;
        end else begin
            k++;
            if (outport_wr) begin
                wr_edge.push_back(k);
                wr_val.push_back(bus_data);
            end
            bprev = ((k - 1) / FR) * FR;
            dv    = last_write(bprev);
            d     = ((k - 1) % FR) / SD;
            upper = dv >> (4 * d);
            e.seg = (blank_lz && d > 0 && upper == 0) ? 8'hFF : hex_tab[upper[3:0]];
            e.en  = ~(8'b1 << d);
            e.q   = last_write(k);
            e.fd  = (k % FR == 0);
        end
        expq.push_back(e);
    end

    // Monitor: compare pins against the oldest prediction
    always @(negedge fast_clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("seg_out", {24'h0, seg_out}, {24'h0, e.seg});
            check("digit_en_n", {24'h0, digit_en_n}, {24'h0, e.en});
            check("outport_q", outport_q, e.q);
            check("frame_done", {31'h0, frame_done}, {31'h0, e.fd});
        end
    end

    task automatic tick();
        @(posedge fast_clk);
        #2;
    endtask

    task automatic do_write(input logic [31:0] v);
        outport_wr = 1'b1;
        bus_data   = v;
        tick();
        outport_wr = 1'b0;
        bus_data   = $urandom;
    endtask

    task automatic align_to_boundary();
        for (int g = 0; g < FR && (k % FR) != FR - 1; g++) tick();
    endtask

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;

        // 0x88 unblanked, then blanked
        do_write(32'h88);
        repeat (2 * FR) tick();
        blank_lz = 1'b1;
        repeat (FR) tick();

        // zero with blanking: only digit 0 lit
        do_write(32'h0);
        repeat (2 * FR) tick();
        blank_lz = 1'b0;

        // back-to-back writes, last one wins
        do_write(32'h89ABCDEF);
        do_write(32'h01234567);
        repeat (2 * FR) tick();

        // write sampled exactly at the boundary edge
        align_to_boundary();
        do_write(32'hFFFFFFFF);
        repeat (2 * FR) tick();

        // async reset while digit 3 is shown
        do_write(32'h12345678);
        repeat (2 * FR) tick();
        for (int g = 0; g < FR && (k % FR) != 13; g++) tick();
        @(negedge fast_clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_seg", {24'h0, seg_out}, 32'hFF);
        check("async_en", {24'h0, digit_en_n}, 32'hFF);
        check("async_q", outport_q, 32'h0);
        check("async_fd", {31'h0, frame_done}, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (FR + 4) tick();

        // randomized writes, zero-heavy data, blank_lz toggling
        for (int n = 0; n < 800; n++) begin
            outport_wr = ($urandom_range(0, 15) == 0);
            bus_data   = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 3) == 0) align_to_boundary();
            tick();
        end
        outport_wr = 1'b0;
        repeat (FR) tick();
        @(negedge fast_clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
